// File: rtl/cardinal_nic.sv
// NIC between one cardinal_cpu core and its ring router: a receive FIFO and a send FIFO,
// exposed to the CPU as four registers, plus the router handshakes.
module cardinal_nic #(
  parameter int DATA_W    = 64,
  parameter int IN_DEPTH  = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  localparam int IN_AW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int OUT_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  logic [0:DATA_W-1] rx_mem_q [IN_DEPTH];
  logic [0:DATA_W-1] tx_mem_q [OUT_DEPTH];

  logic [IN_AW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [OUT_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [IN_CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [OUT_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [0:DATA_W-1] d_out_q, d_out_d;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic cpu_rd, cpu_wr;
  logic [0:DATA_W-1] tx_head;

  assign rx_full  = (rx_cnt_q == IN_CW'(IN_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == OUT_CW'(OUT_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);

  assign cpu_rd = nicEn && !nicWrEn;
  assign cpu_wr = nicEn && nicWrEn;

  // Handshake outputs are held low for the whole time rst is asserted.
  assign net_ri  = !rst && !rx_full;
  assign tx_head = tx_mem_q[tx_rd_q];
  assign net_do  = tx_head;
  // Bit 0 of the head packet is its virtual channel; it only leaves on the matching phase.
  assign net_so  = !rst && !tx_empty && net_ro && (net_polarity == tx_head[0]);

  assign rx_push = net_si && net_ri;
  assign rx_pop  = cpu_rd && (addr == 2'b00) && !rx_empty;
  assign tx_push = !rst && cpu_wr && (addr == 2'b10) && !tx_full;
  assign tx_pop  = net_so;

  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) rx_wr_d = (rx_wr_q == IN_AW'(IN_DEPTH - 1)) ? '0 : rx_wr_q + IN_AW'(1);
    if (rx_pop)  rx_rd_d = (rx_rd_q == IN_AW'(IN_DEPTH - 1)) ? '0 : rx_rd_q + IN_AW'(1);
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + IN_CW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - IN_CW'(1);
  end

  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) tx_wr_d = (tx_wr_q == OUT_AW'(OUT_DEPTH - 1)) ? '0 : tx_wr_q + OUT_AW'(1);
    if (tx_pop)  tx_rd_d = (tx_rd_q == OUT_AW'(OUT_DEPTH - 1)) ? '0 : tx_rd_q + OUT_AW'(1);
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + OUT_CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - OUT_CW'(1);
  end

  // Status registers carry their flag in the last (least significant) bit.
  always_comb begin
    d_out_d = d_out_q;
    if (cpu_rd) begin
      case (addr)
        2'b00:   d_out_d = rx_empty ? '0 : rx_mem_q[rx_rd_q];
        2'b01:   d_out_d = {{(DATA_W-1){1'b0}}, !rx_empty};
        2'b10:   d_out_d = '0;
        default: d_out_d = {{(DATA_W-1){1'b0}}, tx_full};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      d_out_q  <= '0;
    end else begin
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      d_out_q  <= d_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= net_di;
    if (tx_push) tx_mem_q[tx_wr_q] <= d_in;
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed, table-driven bench for cardinal_nic: each record drives one cycle and lists
// the expected handshake outputs before the edge and the expected d_out after it.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'b00;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = '0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_polarity = 1'b0;

  always #5 clk = ~clk;

  cardinal_nic dut (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  addr;
    logic        en;
    logic        wr;
    logic [63:0] din;
    logic        si;
    logic [63:0] di;
    logic        ro;
    logic        pol;
    logic [63:0] exp_dout;
    logic        exp_ri;
    logic        exp_so;
    logic        chk_do;
    logic [63:0] exp_do;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] PKT_AA = 64'h0000_0000_0000_00AA;
  localparam logic [63:0] PKT_A  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] PKT_B  = 64'h2222_2222_2222_2222;
  localparam logic [63:0] PKT_C  = 64'h3333_3333_3333_3333;
  localparam logic [63:0] PKT_D  = 64'h4444_4444_4444_4444;
  localparam logic [63:0] PKT_E  = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PKT_F  = 64'h6666_6666_6666_6666;
  localparam logic [63:0] PKT_G  = 64'h7777_7777_7777_7777;
  localparam logic [63:0] PKT_P  = 64'h8000_0000_0000_0001;
  localparam logic [63:0] PKT_Q1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PKT_Q2 = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] PKT_Q3 = 64'h0555_0555_0555_0555;
  localparam logic [63:0] PKT_R1 = 64'h0000_0000_0000_0A01;
  localparam logic [63:0] PKT_R2 = 64'h0000_0000_0000_0A02;
  localparam logic [63:0] PKT_R3 = 64'h0000_0000_0000_0A03;
  localparam logic [63:0] PKT_S  = 64'h8000_0000_0000_00C5;
  localparam logic [63:0] ONE    = 64'h1;
  localparam logic [63:0] ZERO   = 64'h0;

  task automatic add(input string nm, input logic r, input logic [1:0] a, input logic en,
                     input logic wr, input logic [63:0] din, input logic si,
                     input logic [63:0] di, input logic ro, input logic pol,
                     input logic [63:0] xd, input logic xri, input logic xso,
                     input logic cdo, input logic [63:0] xdo);
    vec_t v;
    v.name = nm; v.rst = r; v.addr = a; v.en = en; v.wr = wr; v.din = din;
    v.si = si; v.di = di; v.ro = ro; v.pol = pol;
    v.exp_dout = xd; v.exp_ri = xri; v.exp_so = xso; v.chk_do = cdo; v.exp_do = xdo;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, check combinational outputs 1ns later,
  // then check the registered read data 1ns after the rising edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    rst = v.rst; addr = v.addr; nicEn = v.en; nicWrEn = v.wr; d_in = v.din;
    net_si = v.si; net_di = v.di; net_ro = v.ro; net_polarity = v.pol;
    #1;
    chk({v.name, "/net_ri"}, {63'b0, net_ri}, {63'b0, v.exp_ri});
    chk({v.name, "/net_so"}, {63'b0, net_so}, {63'b0, v.exp_so});
    if (v.chk_do) chk({v.name, "/net_do"}, net_do, v.exp_do);
    @(posedge clk);
    #1;
    chk({v.name, "/d_out"}, d_out, v.exp_dout);
    n_vec++;
  endtask

  initial begin
    //   name          rst addr  en wr din     si di      ro pol  d_out   ri so cdo net_do
    add("rst0",        1, 2'b00, 0, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   0, 0, 0, ZERO);
    add("rst1",        1, 2'b00, 0, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   0, 0, 0, ZERO);
    add("rd01_init",   0, 2'b01, 1, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    add("rd11_init",   0, 2'b11, 1, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    // single packet from router
    add("rx_aa",       0, 2'b00, 0, 0, ZERO,   1, PKT_AA, 0, 0,   ZERO,   1, 0, 0, ZERO);
    add("rd01_ne",     0, 2'b01, 1, 0, ZERO,   0, ZERO,   0, 0,   ONE,    1, 0, 0, ZERO);
    add("rd00_aa",     0, 2'b00, 1, 0, ZERO,   0, ZERO,   0, 0,   PKT_AA, 1, 0, 0, ZERO);
    add("rd01_empty",  0, 2'b01, 1, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    // fill rx, hold a third packet, pop while it is held
    add("rx_a",        0, 2'b00, 0, 0, ZERO,   1, PKT_A,  0, 0,   ZERO,   1, 0, 0, ZERO);
    add("rx_b",        0, 2'b00, 0, 0, ZERO,   1, PKT_B,  0, 0,   ZERO,   1, 0, 0, ZERO);
    add("rx_c_held",   0, 2'b00, 0, 0, ZERO,   1, PKT_C,  0, 0,   ZERO,   0, 0, 0, ZERO);
    add("rx_c_pop_a",  0, 2'b00, 1, 0, ZERO,   1, PKT_C,  0, 0,   PKT_A,  0, 0, 0, ZERO);
    add("rx_c_accept", 0, 2'b00, 0, 0, ZERO,   1, PKT_C,  0, 0,   PKT_A,  1, 0, 0, ZERO);
    add("rd00_b",      0, 2'b00, 1, 0, ZERO,   0, ZERO,   0, 0,   PKT_B,  0, 0, 0, ZERO);
    add("rd00_c",      0, 2'b00, 1, 0, ZERO,   0, ZERO,   0, 0,   PKT_C,  1, 0, 0, ZERO);
    add("rd00_empty",  0, 2'b00, 1, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    // simultaneous push/pop keeps count; no bypass when empty
    add("rx_d",        0, 2'b00, 0, 0, ZERO,   1, PKT_D,  0, 0,   ZERO,   1, 0, 0, ZERO);
    add("rx_e_pop_d",  0, 2'b00, 1, 0, ZERO,   1, PKT_E,  0, 0,   PKT_D,  1, 0, 0, ZERO);
    add("rd00_e",      0, 2'b00, 1, 0, ZERO,   0, ZERO,   0, 0,   PKT_E,  1, 0, 0, ZERO);
    add("rd01_after_e",0, 2'b01, 1, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    add("rx_f_nobyp",  0, 2'b00, 1, 0, ZERO,   1, PKT_F,  0, 0,   ZERO,   1, 0, 0, ZERO);
    add("rd00_f",      0, 2'b00, 1, 0, ZERO,   0, ZERO,   0, 0,   PKT_F,  1, 0, 0, ZERO);
    // polarity gating of the send side
    add("wr10_p",      0, 2'b10, 1, 1, PKT_P,  0, ZERO,   1, 0,   PKT_F,  1, 0, 0, ZERO);
    add("p_wrong_pol", 0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 0,   PKT_F,  1, 0, 1, PKT_P);
    add("p_send",      0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 1,   PKT_F,  1, 1, 1, PKT_P);
    add("p_gone",      0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 1,   PKT_F,  1, 0, 0, ZERO);
    add("rd11_nf",     0, 2'b11, 1, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    // overflow writes are dropped; two leave in order
    add("wr_q1",       0, 2'b10, 1, 1, PKT_Q1, 0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    add("wr_q2",       0, 2'b10, 1, 1, PKT_Q2, 0, ZERO,   0, 0,   ZERO,   1, 0, 1, PKT_Q1);
    add("wr_q3_drop",  0, 2'b10, 1, 1, PKT_Q3, 0, ZERO,   0, 0,   ZERO,   1, 0, 1, PKT_Q1);
    add("rd11_full",   0, 2'b11, 1, 0, ZERO,   0, ZERO,   0, 0,   ONE,    1, 0, 1, PKT_Q1);
    add("send_q1",     0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 0,   ONE,    1, 1, 1, PKT_Q1);
    add("send_q2",     0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 0,   ONE,    1, 1, 1, PKT_Q2);
    add("send_none",   0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 0,   ONE,    1, 0, 0, ZERO);
    add("rd11_empty",  0, 2'b11, 1, 0, ZERO,   0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    // write while full in the same cycle as a send pop is still dropped
    add("wr_r1",       0, 2'b10, 1, 1, PKT_R1, 0, ZERO,   0, 0,   ZERO,   1, 0, 0, ZERO);
    add("wr_r2",       0, 2'b10, 1, 1, PKT_R2, 0, ZERO,   0, 0,   ZERO,   1, 0, 1, PKT_R1);
    add("wr_r3_pop",   0, 2'b10, 1, 1, PKT_R3, 0, ZERO,   1, 0,   ZERO,   1, 1, 1, PKT_R1);
    add("send_r2",     0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 0,   ZERO,   1, 1, 1, PKT_R2);
    add("no_r3",       0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 0,   ZERO,   1, 0, 0, ZERO);
    // writes to non-send addresses do not touch either FIFO
    add("wr00_ign",    0, 2'b00, 1, 1, PKT_G,  0, ZERO,   1, 0,   ZERO,   1, 0, 0, ZERO);
    add("rd01_ign",    0, 2'b01, 1, 0, ZERO,   0, ZERO,   1, 0,   ZERO,   1, 0, 0, ZERO);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Reset while both FIFOs hold packets and d_out is non-zero.
    tbl.delete();
    add("mr_rx_g",     0, 2'b00, 0, 0, ZERO,   1, PKT_G,  0, 0,   ZERO,   1, 0, 0, ZERO);
    add("mr_rx_a",     0, 2'b00, 0, 0, ZERO,   1, PKT_A,  0, 0,   ZERO,   1, 0, 0, ZERO);
    add("mr_wr_s",     0, 2'b10, 1, 1, PKT_S,  0, ZERO,   0, 0,   ZERO,   0, 0, 0, ZERO);
    add("mr_rd01",     0, 2'b01, 1, 0, ZERO,   0, ZERO,   0, 0,   ONE,    0, 0, 1, PKT_S);
    add("mr_rst",      1, 2'b00, 0, 0, ZERO,   1, PKT_B,  1, 1,   ZERO,   0, 0, 0, ZERO);
    add("mr_post",     0, 2'b00, 0, 0, ZERO,   0, ZERO,   1, 1,   ZERO,   1, 0, 0, ZERO);
    add("mr_rd01",     0, 2'b01, 1, 0, ZERO,   0, ZERO,   1, 1,   ZERO,   1, 0, 0, ZERO);
    add("mr_rd11",     0, 2'b11, 1, 0, ZERO,   0, ZERO,   1, 1,   ZERO,   1, 0, 0, ZERO);
    add("mr_rd00",     0, 2'b00, 1, 0, ZERO,   0, ZERO,   1, 1,   ZERO,   1, 0, 0, ZERO);
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Network interface controller that sits between one cardinal_cpu core and its ring router in the chip multiprocessor.
- Owns two packet FIFOs and exposes them to the CPU as four 64-bit registers, selected by the CPU's 2-bit NIC address.
  - Input side: receive FIFO plus status.
  - Output side: send FIFO plus status.
- Sequences the router handshakes: accepts packets from the router, and injects CPU packets only when the link is ready and the polarity matches.

Parameters:
- DATA_W, 64: packet and register width. Bit ordering is [0:DATA_W-1]; bit 0 is the MSB.
- IN_DEPTH, 2: receive FIFO depth in packets. Power of 2, at least 1.
- OUT_DEPTH, 2: send FIFO depth in packets. Power of 2, at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  2  register select, [0:1]. 00 = input buffer, 01 = input status, 10 = output buffer, 11 = output status.
- d_in  in  DATA_W  write data from the CPU.
- d_out  out  DATA_W  read data to the CPU; registered.
- nicEn  in  1  access strobe.
- nicWrEn  in  1  1 = write, 0 = read; valid only when nicEn=1.
- net_si  in  1  router presents a packet on net_di.
- net_ri  out  1  NIC can accept a packet.
- net_di  in  DATA_W  packet from the router.
- net_so  out  1  NIC presents a packet on net_do.
- net_ro  in  1  router can accept a packet.
- net_do  out  DATA_W  packet to the router (head of the send FIFO).
- net_polarity  in  1  router's current even/odd phase.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both FIFOs empty; all pointers and counts 0; d_out = 0.
  - net_ri and net_so are forced to 0 combinationally for as long as rst is high.
  - Reset in the middle of a transfer discards all buffered packets.
- Clocking: one clock domain; reset is synchronous and active-high.
- CPU read (nicEn=1, nicWrEn=0):
  - d_out is loaded at the edge and is valid for the whole next cycle. This gives one cycle of latency, matching the CPU, which samples NIC data one stage after it issues the access.
  - addr 00, FIFO non-empty: d_out = head of receive FIFO; the head is popped.
  - addr 00, FIFO empty: d_out = 0; no state change.
  - addr 01: d_out = 63'b0 followed by a non-empty flag in bit 63.
  - addr 11: d_out = 63'b0 followed by the send-FIFO full flag in bit 63.
  - addr 10: d_out = 0.
  - When nicEn=0, d_out holds its value.
- CPU write (nicEn=1, nicWrEn=1):
  - addr 10, send FIFO not full: push d_in.
  - addr 10, send FIFO full: the write is dropped silently. Software must poll addr 11 before writing.
  - Writes to 00, 01 and 11 are ignored.
- Receive handshake:
  - net_ri = !rx_full, combinational.
  - A push happens at an edge where net_si=1 and net_ri=1; net_di is captured.
  - net_si while net_ri=0 is ignored; the router must hold the packet.
  - A pop by the CPU at addr 00 in the same cycle as a push is legal. The count is unchanged, the popped packet is the old head, and there is no bypass of an empty FIFO.
- Send handshake:
  - net_so = !tx_empty && net_ro && (net_polarity == head[0]), combinational. head[0] is the packet's virtual-channel bit.
  - net_do = head of the send FIFO at all times; its value is don't-care when the FIFO is empty.
  - The head is popped at an edge where net_so=1.
  - A CPU write at addr 10 in the same cycle as a send pop is accepted only if the FIFO was not full at the start of that cycle.
- FIFO pointers:
  - Read and write pointers wrap modulo the depth.
  - Each FIFO has a count of log2(depth)+1 bits; full = (count == depth), empty = (count == 0).
  - The count is unchanged when a push and a pop occur in the same cycle.

Test Plan:
- Reset, then read addr 01 and addr 11: d_out = 0 both times; net_ri = 1; net_so = 0.
- Router sends 64'h0000_0000_0000_00AA with net_si=1 for 1 cycle, then CPU reads 01 and then 00:
  - status read gives d_out[63] = 1;
  - next read gives d_out = ...AA;
  - a further 01 read gives 0.
- Router pushes 2 packets (A, B), then holds a third with net_si=1:
  - net_ri goes to 0 after the second packet; the third is not accepted;
  - a CPU pop of A in the same cycle as the held third packet does not accept it that cycle; net_ri returns to 1 the following cycle and the third packet is accepted then;
  - reads return A, then B, then the third packet.
- CPU writes 64'h8000_0000_0000_0001 (VC bit = 1) to addr 10 with net_ro=1 and net_polarity=0:
  - net_so stays 0;
  - when net_polarity goes to 1, net_so = 1 for exactly 1 cycle; net_do = 8000...0001; the send FIFO becomes empty.
- With net_ro=0, CPU writes 3 packets to addr 10:
  - the third write is dropped; an addr 11 read gives d_out[63] = 1;
  - after net_ro=1, exactly 2 packets leave, in order.
- Assert rst while both FIFOs hold packets: next cycle both FIFOs are empty, d_out = 0, and net_so = 0.
